// File: rtl/intersection_phase_scheduler_if.sv
// Bundles the demand inputs and lamp outputs of one intersection scheduler.
// Latency: not applicable (wires only).
// Backpressure: none; every signal is a level sampled or driven each cycle.
interface intersection_phase_scheduler_if #(
    parameter int N_PHASES = 4
);
    localparam int PW = $clog2(N_PHASES);

    logic [N_PHASES-1:0] req;
    logic                ped_req;
    logic                preempt;
    logic [PW-1:0]       preempt_phase;

    logic [N_PHASES-1:0] phase_green;
    logic [N_PHASES-1:0] phase_yellow;
    logic                walk;
    logic [PW-1:0]       cur_phase;
    logic [N_PHASES-1:0] pending;
    logic                ped_pending;

    // Side that produces demand and consumes lamp states.
    modport master (
        output req, ped_req, preempt, preempt_phase,
        input  phase_green, phase_yellow, walk, cur_phase, pending, ped_pending
    );

    // Scheduler side.
    modport slave (
        input  req, ped_req, preempt, preempt_phase,
        output phase_green, phase_yellow, walk, cur_phase, pending, ped_pending
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Round-robin actuated phase scheduler: GREEN -> YELLOW -> all-red -> IDLE, ped walk, preemption.
// Latency: one edge from qualifying demand in IDLE to lamp change; all outputs registered.
// Backpressure: none; demand is latched until served, preempt is a level.
module intersection_phase_scheduler #(
    parameter int N_PHASES  = 4,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 4,
    parameter int TW        = 8
) (
    input logic clk,
    input logic rst,
    intersection_phase_scheduler_if.slave bus
);
    localparam int PW = $clog2(N_PHASES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_WALK,
        S_CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [PW-1:0]       last_q, last_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [TW-1:0]       elapsed_q, elapsed_d;
    logic [N_PHASES-1:0] pending_q, pending_d;
    logic                ped_q, ped_d;
    logic [N_PHASES-1:0] green_q, green_d;
    logic [N_PHASES-1:0] yellow_q, yellow_d;
    logic                walk_q, walk_d;

    logic                pv;
    logic [N_PHASES-1:0] demand;
    logic                ped_demand;
    logic [N_PHASES-1:0] cur_mask;
    logic                other;
    logic                gap_out;
    logic                max_out;
    logic                pre_other;
    logic                pre_hold;
    logic                rr_found;
    logic [PW-1:0]       rr_idx;
    logic [PW-1:0]       cand;

    assign pv         = bus.preempt && (int'(bus.preempt_phase) < N_PHASES);
    assign demand     = pending_q | bus.req;
    assign ped_demand = ped_q | bus.ped_req;

    // Green exit qualifiers for the phase currently holding the grant.
    always_comb begin
        cur_mask          = '0;
        cur_mask[phase_q] = 1'b1;
        other     = ped_demand | (|(demand & ~cur_mask));
        gap_out   = (elapsed_q >= TW'(GREEN_MIN)) && !bus.req[phase_q];
        max_out   = (elapsed_q >= TW'(GREEN_MAX)) && other;
        pre_other = pv && (bus.preempt_phase != phase_q);
        pre_hold  = pv && (bus.preempt_phase == phase_q);
    end

    // Round-robin search: first phase with demand after the last car grant, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= N_PHASES; k++) begin
            cand = PW'((int'(last_q) + k) % N_PHASES);
            if (!rr_found && demand[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Next state, timers, demand latches and next lamp values.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        last_d    = last_q;
        timer_d   = timer_q;
        elapsed_d = elapsed_q;

        case (state_q)
            S_IDLE: begin
                if (pv) begin
                    state_d   = S_GREEN;
                    phase_d   = bus.preempt_phase;
                    last_d    = bus.preempt_phase;
                    elapsed_d = TW'(1);
                end else if (ped_demand) begin
                    state_d = S_WALK;
                    timer_d = TW'(WALK_T - 1);
                end else if (rr_found) begin
                    state_d   = S_GREEN;
                    phase_d   = rr_idx;
                    last_d    = rr_idx;
                    elapsed_d = TW'(1);
                end
            end
            S_GREEN: begin
                // A preempt aimed at the running phase freezes it in green.
                if (pre_other || (!pre_hold && (gap_out || max_out))) begin
                    state_d   = S_YELLOW;
                    timer_d   = TW'(YELLOW_T - 1);
                    elapsed_d = '0;
                end else if (elapsed_q < TW'(GREEN_MAX)) begin
                    elapsed_d = elapsed_q + 1'b1;
                end
            end
            S_YELLOW: begin
                if (timer_q == '0) begin
                    state_d = S_CLEAR;
                    timer_d = TW'(ALLRED_T - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_WALK: begin
                if (pv || timer_q == '0) begin
                    state_d = S_CLEAR;
                    timer_d = TW'(ALLRED_T - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_CLEAR: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Car demand latches unless that phase is already green; a grant clears it.
        for (int i = 0; i < N_PHASES; i++) begin
            pending_d[i] = pending_q[i] |
                           (bus.req[i] & !(state_q == S_GREEN && phase_q == PW'(i)));
        end
        if (state_d == S_GREEN) begin
            pending_d[phase_d] = 1'b0;
        end

        // Ped demand latches outside WALK; entering WALK clears it and wins.
        ped_d = ped_q | (bus.ped_req & (state_q != S_WALK));
        if (state_q != S_WALK && state_d == S_WALK) begin
            ped_d = 1'b0;
        end

        green_d  = '0;
        yellow_d = '0;
        walk_d   = (state_d == S_WALK);
        if (state_d == S_GREEN) begin
            green_d[phase_d] = 1'b1;
        end
        if (state_d == S_YELLOW) begin
            yellow_d[phase_d] = 1'b1;
        end
    end

    // State, timers and registered lamp outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            last_q    <= PW'(N_PHASES - 1);
            timer_q   <= '0;
            elapsed_q <= '0;
            pending_q <= '0;
            ped_q     <= 1'b0;
            green_q   <= '0;
            yellow_q  <= '0;
            walk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            elapsed_q <= elapsed_d;
            pending_q <= pending_d;
            ped_q     <= ped_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            walk_q    <= walk_d;
        end
    end

    assign bus.phase_green  = green_q;
    assign bus.phase_yellow = yellow_q;
    assign bus.walk         = walk_q;
    assign bus.cur_phase    = phase_q;
    assign bus.pending      = pending_q;
    assign bus.ped_pending  = ped_q;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for the intersection scheduler with a lamp-level reference model.
// Latency: model advances on each rising edge; outputs compared on each falling edge.
// Backpressure: none; stimulus is driven on falling edges.
module tb_intersection_phase_scheduler;
    localparam int N         = 4;
    localparam int GREEN_MIN = 5;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    intersection_phase_scheduler_if #(.N_PHASES(N)) ifc ();

    intersection_phase_scheduler #(
        .N_PHASES(N), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T), .TW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Reference model: which lamp is lit and for how many cycles it has been lit.
    int       m_g, m_y, m_age, m_last, m_cur;
    bit       m_walk, m_clr, m_pedp;
    bit [N-1:0] m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_g = -1; m_y = -1; m_walk = 0; m_clr = 0; m_age = 0;
        m_last = N - 1; m_cur = 0; m_pend = '0; m_pedp = 0;
    endtask

    task automatic model_step();
        bit [N-1:0] dem;
        bit pdem, pv, other, same, nw, nc;
        int pp, ng, ny, pick;
        dem  = m_pend | ifc.req;
        pdem = m_pedp | ifc.ped_req;
        pp   = int'(ifc.preempt_phase);
        pv   = ifc.preempt && pp < N;
        ng = -1; ny = -1; nw = 0; nc = 0; pick = -1;
        if (m_g >= 0) begin
            other = pdem;
            for (int j = 0; j < N; j++) if (j != m_g && dem[j]) other = 1;
            if (pv && pp != m_g) ny = m_g;
            else if (!pv && ((m_age >= GREEN_MIN && !ifc.req[m_g]) ||
                             (m_age >= GREEN_MAX && other))) ny = m_g;
            else ng = m_g;
        end else if (m_y >= 0) begin
            if (m_age >= YELLOW_T) nc = 1; else ny = m_y;
        end else if (m_walk) begin
            if (pv || m_age >= WALK_T) nc = 1; else nw = 1;
        end else if (m_clr) begin
            if (m_age < ALLRED_T) nc = 1;
        end else begin
            if (pv) pick = pp;
            else if (pdem) nw = 1;
            else for (int k = 1; k <= N; k++)
                if (pick < 0 && dem[(m_last + k) % N]) pick = (m_last + k) % N;
            if (pick >= 0) begin ng = pick; m_last = pick; m_cur = pick; end
        end
        for (int i = 0; i < N; i++) if (ifc.req[i] && m_g != i) m_pend[i] = 1;
        if (ng >= 0) m_pend[ng] = 0;
        if (ifc.ped_req && !m_walk) m_pedp = 1;
        if (nw && !m_walk) m_pedp = 0;
        same = (ng >= 0 && ng == m_g) || (ny >= 0 && ny == m_y) || (nw && m_walk) || (nc && m_clr);
        m_age = same ? ((m_age < 1000) ? m_age + 1 : m_age) : 1;
        m_g = ng; m_y = ny; m_walk = nw; m_clr = nc;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model, plus the lamp exclusivity rule.
    initial begin
        logic [15:0] exp_v, act_v;
        logic [N-1:0] eg, ey;
        forever begin
            @(negedge clk);
            eg = '0; ey = '0;
            if (m_g >= 0) eg[m_g] = 1'b1;
            if (m_y >= 0) ey[m_y] = 1'b1;
            exp_v = {eg, ey, m_walk, 2'(m_cur), m_pend, m_pedp};
            act_v = {ifc.phase_green, ifc.phase_yellow, ifc.walk, ifc.cur_phase,
                     ifc.pending, ifc.ped_pending};
            check("model_compare", 32'(act_v), 32'(exp_v));
            check("lamp_exclusive",
                  32'($countones({ifc.phase_green, ifc.phase_yellow, ifc.walk}) <= 1), 32'd1);
        end
    end

    // Counts consecutive sampled cycles showing the given lamp pattern, starting now.
    task automatic expect_run(input string name, input logic [N-1:0] g, input logic [N-1:0] y,
                              input logic w, input int n_exp);
        int n = 0;
        while (n < 60 && ifc.phase_green == g && ifc.phase_yellow == y && ifc.walk == w) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'(n_exp));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ifc.req = '0; ifc.ped_req = 1'b0; ifc.preempt = 1'b0; ifc.preempt_phase = '0;
        tick(2);
        check("reset_green", 32'(ifc.phase_green), 32'h0);
        check("reset_cur", 32'(ifc.cur_phase), 32'h0);
        check("reset_pending", 32'(ifc.pending), 32'h0);
        rst = 1'b0;
        tick(1);

        // Single-cycle request on phase 0: 5 green, 2 yellow.
        ifc.req = 4'b0001; tick(1); ifc.req = '0;
        check("t2_grant", 32'(ifc.phase_green), 32'h1);
        expect_run("t2_green", 4'b0001, 4'b0000, 1'b0, 5);
        expect_run("t2_yellow", 4'b0000, 4'b0001, 1'b0, 2);
        tick(3);
        check("t2_idle_pending", 32'(ifc.pending), 32'h0);

        // Round robin from last=0 with phases 0, 2, 3 requested together.
        ifc.req = 4'b1101; tick(1); ifc.req = '0;
        check("rr_first", 32'(ifc.phase_green), 32'h4);
        check("rr_pend1", 32'(ifc.pending), 32'h9);
        expect_run("rr_g2", 4'b0100, 4'b0000, 1'b0, 5);
        expect_run("rr_y2", 4'b0000, 4'b0100, 1'b0, 2);
        expect_run("rr_red2", 4'b0000, 4'b0000, 1'b0, 2);
        check("rr_second", 32'(ifc.phase_green), 32'h8);
        check("rr_pend2", 32'(ifc.pending), 32'h1);
        expect_run("rr_g3", 4'b1000, 4'b0000, 1'b0, 5);
        expect_run("rr_y3", 4'b0000, 4'b1000, 1'b0, 2);
        expect_run("rr_red3", 4'b0000, 4'b0000, 1'b0, 2);
        check("rr_third", 32'(ifc.phase_green), 32'h1);
        check("rr_pend3", 32'(ifc.pending), 32'h0);
        expect_run("rr_g0", 4'b0001, 4'b0000, 1'b0, 5);
        tick(4);

        // Max-out: phase 1 held, phase 2 pulsed at elapsed 8.
        ifc.req = 4'b0010; tick(1);
        tick(7);
        ifc.req = 4'b0110; tick(1); ifc.req = 4'b0010;
        expect_run("mx_g1_rest", 4'b0010, 4'b0000, 1'b0, 12);
        expect_run("mx_y1", 4'b0000, 4'b0010, 1'b0, 2);
        expect_run("mx_red", 4'b0000, 4'b0000, 1'b0, 2);
        check("mx_next", 32'(ifc.phase_green), 32'h4);
        check("mx_pend", 32'(ifc.pending), 32'h2);
        ifc.req = '0;
        expect_run("mx_g2", 4'b0100, 4'b0000, 1'b0, 5);
        tick(16);

        // Ped pulse while phase 0 is held green: max-out, then walk.
        ifc.req = 4'b0001; tick(1);
        ifc.ped_req = 1'b1; tick(1); ifc.ped_req = 1'b0;
        check("ped_latched", 32'(ifc.ped_pending), 32'h1);
        expect_run("ped_g0", 4'b0001, 4'b0000, 1'b0, 19);
        ifc.req = '0;
        expect_run("ped_y0", 4'b0000, 4'b0001, 1'b0, 2);
        expect_run("ped_red", 4'b0000, 4'b0000, 1'b0, 2);
        expect_run("ped_walk", 4'b0000, 4'b0000, 1'b1, 4);
        check("ped_cleared", 32'(ifc.ped_pending), 32'h0);
        tick(3);

        // Preempt to phase 3 at phase 0 elapsed 2.
        ifc.req = 4'b0001; tick(1); tick(1);
        ifc.preempt = 1'b1; ifc.preempt_phase = 2'd3; tick(1);
        check("pre_yellow", 32'(ifc.phase_yellow), 32'h1);
        expect_run("pre_y0", 4'b0000, 4'b0001, 1'b0, 2);
        expect_run("pre_red", 4'b0000, 4'b0000, 1'b0, 2);
        check("pre_green3", 32'(ifc.phase_green), 32'h8);
        check("pre_cur3", 32'(ifc.cur_phase), 32'h3);
        tick(10);
        check("pre_hold3", 32'(ifc.phase_green), 32'h8);
        ifc.preempt = 1'b0; ifc.req = '0; tick(1);
        check("pre_release", 32'(ifc.phase_yellow), 32'h8);
        tick(16);

        // Preempt aborts a walk straight into clearance.
        ifc.ped_req = 1'b1; tick(1); ifc.ped_req = 1'b0;
        check("abort_walk_on", 32'(ifc.walk), 32'h1);
        tick(1);
        ifc.preempt = 1'b1; ifc.preempt_phase = 2'd1; tick(1);
        check("abort_walk_off", 32'({ifc.walk, ifc.phase_green}), 32'h0);
        tick(2);
        check("abort_green1", 32'(ifc.phase_green), 32'h2);
        ifc.preempt = 1'b0; tick(14);

        // Asynchronous reset in the middle of green on phase 2.
        ifc.req = 4'b0101; tick(1); tick(1);
        #2 rst = 1'b1;
        #1 check("arst_outputs", 32'({ifc.phase_green, ifc.phase_yellow, ifc.walk, ifc.pending}), 32'h0);
        tick(1);
        rst = 1'b0; ifc.req = '0; tick(1);
        check("arst_idle", 32'({ifc.phase_green, ifc.pending}), 32'h0);
        ifc.req = 4'b1111; tick(1); ifc.req = '0;
        check("arst_ptr", 32'(ifc.phase_green), 32'h1);
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
